// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: I/O window decode constants and status-byte packing shared by the bridge
package mem_io_bridge_pkg;
  localparam int RAM_AW_DEF = 17;
  localparam int TXF_DEPTH_DEF = 8;
  localparam int TXF_AW_DEF = 3;
  localparam logic [1:0] IO_SEL = 2'b11;
  typedef enum logic [2:0] {
    UART_DATA = 3'd0,
    STATUS_HALT = 3'd4
  } io_off_e;
  function automatic logic [7:0] status_byte(input logic rx_valid, input logic tx_full);
    return {6'b0, rx_valid, tx_full};
  endfunction
endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// tx_fifo: circular byte FIFO; a push into a full FIFO is accepted only when a pop frees the slot
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          en,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout = mem_q[rd_ptr_q];
  always_comb begin
    do_pop = en & pop & ~empty;
    do_push = en & push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU byte accesses to block RAM or the UART/halt I/O window at 0x30000,
// returning read data one cycle after the address for both targets.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int TXF_DEPTH = TXF_DEPTH_DEF,
  parameter int TXF_AW = TXF_AW_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  input  logic [7:0]        ram_din,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ack,
  output logic              io_buffer_full,
  output logic              tx_overflow,
  output logic              program_finish,
  output logic [7:0]        exit_code
);
  logic is_io, io_wr, io_rd, push, pop, halt_wr, fifo_full, fifo_empty;
  logic [2:0] off;
  logic [TXF_AW:0] fifo_count;
  logic sel_q, sel_d, ram_rd_q, ram_rd_d, ack_q, ack_d, ovf_q, ovf_d, fin_q, fin_d;
  logic [7:0] io_q, io_d, exit_q, exit_d;
  logic unused_a;
  assign unused_a = ^cpu_a[31:18];
  assign ram_a = cpu_a[RAM_AW-1:0];
  assign ram_dout = cpu_dout;
  assign ram_we = cpu_wr & ~is_io & rdy_in;
  assign uart_tx_valid = ~fifo_empty;
  assign io_buffer_full = fifo_count == (TXF_AW+1)'(TXF_DEPTH);
  assign uart_rx_ack = ack_q;
  assign tx_overflow = ovf_q;
  assign program_finish = fin_q;
  assign exit_code = exit_q;
  // ram_rd_q keeps cpu_din at zero after reset until a RAM access actually returns data
  assign cpu_din = sel_q ? io_q : ram_rd_q ? ram_din : 8'h00;
  always_comb begin
    is_io = cpu_a[17:16] == IO_SEL;
    off = cpu_a[2:0];
    io_wr = is_io & cpu_wr & rdy_in;
    io_rd = is_io & ~cpu_wr & rdy_in;
    push = io_wr & (off == UART_DATA);
    halt_wr = io_wr & (off == STATUS_HALT);
    pop = uart_tx_valid & uart_tx_ready & rdy_in;
    sel_d = rdy_in ? is_io : sel_q;
    ram_rd_d = rdy_in ? ~is_io : ram_rd_q;
    ack_d = io_rd & (off == UART_DATA) & uart_rx_valid;
    io_d = !io_rd ? io_q :
           off == UART_DATA ? (uart_rx_valid ? uart_rx_data : 8'h00) :
           off == STATUS_HALT ? status_byte(uart_rx_valid, fifo_full) : 8'h00;
    ovf_d = ovf_q | (push & fifo_full & ~pop);
    fin_d = fin_q | halt_wr;
    exit_d = halt_wr ? cpu_dout : exit_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sel_q <= 1'b0;
      ram_rd_q <= 1'b0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
      fin_q <= 1'b0;
      io_q <= 8'h00;
      exit_q <= 8'h00;
    end else begin
      sel_q <= sel_d;
      ram_rd_q <= ram_rd_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
      fin_q <= fin_d;
      io_q <= io_d;
      exit_q <= exit_d;
    end
  end
  tx_fifo #(.DEPTH(TXF_DEPTH), .AW(TXF_AW)) u_txf (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in),
    .push   (push),
    .pop    (pop),
    .din    (cpu_dout),
    .dout   (uart_tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: directed and random CPU traffic checked against a queue-based model of the bridge
module tb_mem_io_bridge;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, cpu_wr, ram_we, uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ack;
  logic io_buffer_full, tx_overflow, program_finish;
  logic [31:0] cpu_a;
  logic [16:0] ram_a;
  logic [7:0] cpu_dout, cpu_din, ram_dout, ram_din = 8'h00, uart_tx_data, uart_rx_data, exit_code;
  int checks = 0, failures = 0;
  bit [7:0] ram [131072];
  bit [7:0] ref_mem [131072];
  logic [7:0] q[$], sent[$];
  logic ovf, fin, exp_ack, din_ok;
  logic [7:0] code, exp_din;

  mem_io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_din(ram_din), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ack(uart_rx_ack), .io_buffer_full(io_buffer_full), .tx_overflow(tx_overflow),
    .program_finish(program_finish), .exit_code(exit_code)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rdy_in) begin
      ram_din <= ram[ram_a];
      if (ram_we) ram[ram_a] <= ram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic wr, input logic rdy,
                     input logic txr, input logic rxv, input logic [7:0] rxd, input logic rst);
    logic io, full, pop;
    cpu_a = a; cpu_dout = d; cpu_wr = wr; rdy_in = rdy;
    uart_tx_ready = txr; uart_rx_valid = rxv; uart_rx_data = rxd; rst_in = rst;
    #1;
    io = a[17:16] == 2'b11;
    chk("ram_we", ram_we, wr & ~io & rdy);
    chk("ram_a", ram_a, a[16:0]);
    full = q.size() == 8;
    pop = q.size() != 0 && txr && rdy;
    if (pop && rst) sent.push_back(uart_tx_data);
    if (rdy && wr && !io) ref_mem[a[16:0]] = d;
    if (!rst) begin
      q.delete(); ovf = 0; fin = 0; code = 0; exp_ack = 0; exp_din = 0; din_ok = 1;
    end else if (rdy) begin
      if (pop) void'(q.pop_front());
      if (io && wr && a[2:0] == 3'd0) begin
        if (full && !pop) ovf = 1;
        else q.push_back(d);
      end
      if (io && wr && a[2:0] == 3'd4) begin fin = 1; code = d; end
      exp_ack = io && !wr && a[2:0] == 3'd0 && rxv;
      din_ok = !wr;
      exp_din = !io ? ref_mem[a[16:0]] : a[2:0] == 3'd0 ? (rxv ? rxd : 8'h00) :
                a[2:0] == 3'd4 ? {6'b0, rxv, full} : 8'h00;
    end else exp_ack = 0;
    @(posedge clk_in); #1;
    chk("tx_valid", uart_tx_valid, q.size() != 0);
    if (q.size() != 0) chk("tx_data", uart_tx_data, q[0]);
    chk("buf_full", io_buffer_full, q.size() == 8);
    chk("tx_ovf", tx_overflow, ovf);
    chk("finish", program_finish, fin);
    chk("exit_code", exit_code, code);
    chk("rx_ack", uart_rx_ack, exp_ack);
    if (din_ok) chk("cpu_din", cpu_din, exp_din);
  endtask

  task automatic rst_cyc();
    cyc(32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr_io(input logic [31:0] a, input logic [7:0] d, input logic txr);
    cyc(a, d, 1'b1, 1'b1, txr, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst_cyc();
    rst_cyc();
    chk("rst_din", cpu_din, 8'h00);
    chk("rst_txv", uart_tx_valid, 1'b0);
    // RAM write then read-back one cycle later
    cyc(32'h00123, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(32'h00123, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ram_rd", cpu_din, 8'hA5);
    // fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) wr_io(32'h30000, 8'(i), 1'b0);
    chk("full8", io_buffer_full, 1'b1);
    wr_io(32'h30000, 8'h09, 1'b0);
    chk("ovf9", tx_overflow, 1'b1);
    sent.delete();
    repeat (10) cyc(32'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("drain_n", sent.size(), 8);
    for (int i = 0; i < sent.size(); i++) chk("drain", sent[i], i + 1);
    // push into a full FIFO while it pops, then sustained push+pop across pointer wrap
    rst_cyc();
    for (int i = 1; i <= 8; i++) wr_io(32'h30000, 8'(i), 1'b0);
    wr_io(32'h30000, 8'h55, 1'b1);
    chk("fullpp_full", io_buffer_full, 1'b1);
    chk("fullpp_ovf", tx_overflow, 1'b0);
    chk("fullpp_head", uart_tx_data, 8'h02);
    for (int i = 0; i < 20; i++) wr_io(32'h30000, 8'(8'h60 + i), 1'b1);
    chk("wrap_head", uart_tx_data, 8'h6C);
    repeat (9) cyc(32'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    // RX handshake
    rst_cyc();
    cyc(32'h30000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1);
    chk("rx_din", cpu_din, 8'h3C);
    chk("rx_ack1", uart_rx_ack, 1'b1);
    cyc(32'h00010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1);
    chk("rx_ack2", uart_rx_ack, 1'b0);
    cyc(32'h30000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
    chk("rx_none_din", cpu_din, 8'h00);
    chk("rx_none_ack", uart_rx_ack, 1'b0);
    // status and halt
    for (int i = 1; i <= 8; i++) wr_io(32'h30000, 8'(i), 1'b0);
    cyc(32'h30004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("status", cpu_din, 8'h03);
    wr_io(32'h30004, 8'h2A, 1'b0);
    chk("halt", program_finish, 1'b1);
    chk("halt_code", exit_code, 8'h2A);
    // rdy_in low freezes everything; reset with bytes queued
    rst_cyc();
    for (int i = 1; i <= 3; i++) wr_io(32'h30000, 8'(8'h40 + i), 1'b0);
    cyc(32'h00123, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(i[0] ? 32'h30000 : 32'h00123, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
    chk("hold_din", cpu_din, 8'hA5);
    chk("hold_head", uart_tx_data, 8'h41);
    rst_cyc();
    chk("rst_mid_txv", uart_tx_valid, 1'b0);
    chk("rst_mid_full", io_buffer_full, 1'b0);
    chk("rst_mid_fin", program_finish, 1'b0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int r;
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r < 5) a[17:0] = 18'($urandom_range(0, 15)) * 18'h2111;
      else begin
        a[17:16] = 2'b11;
        a[2:0] = r < 7 ? 3'd0 : r < 9 ? 3'd4 : 3'($urandom);
      end
      cyc(a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
          $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 199) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU's byte-wide memory port (address, data out, write strobe, data in).
- Decodes each access to either the 128 KiB block RAM or the I/O window at 0x30000.
- Owns an 8-entry UART TX FIFO, a UART RX handshake, a status register and a program-finish latch.
- Returns read data to the CPU with a fixed 1-cycle latency, matching the synchronous RAM.

Parameters:
- RAM_AW, 17, RAM byte-address width.
- TXF_DEPTH, 8, TX FIFO entries; must be a power of 2.
- TXF_AW, 3, log2(TXF_DEPTH).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global enable; when low, all state holds
- cpu_a  in  32  CPU byte address; only bits 17:0 are decoded
- cpu_dout  in  8  CPU write data
- cpu_wr  in  1  1 = write, 0 = read
- cpu_din  out  8  read data to CPU, valid 1 cycle after the address
- ram_a  out  RAM_AW  RAM address
- ram_dout  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_din  in  8  RAM read data, synchronous 1-cycle
- uart_tx_data  out  8  FIFO head byte
- uart_tx_valid  out  1  FIFO not empty
- uart_tx_ready  in  1  UART accepts the head byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ack  out  1  1-cycle pulse: byte consumed
- io_buffer_full  out  1  TX FIFO full; CPU stalls I/O writes on this
- tx_overflow  out  1  sticky: a write arrived while the FIFO was full
- program_finish  out  1  sticky halt flag
- exit_code  out  8  byte written with the halt request

Behaviour:
- Reset: on rst_in==0 at a clock edge, the following are cleared to 0:
  - FIFO pointers and count; tx_overflow, program_finish, exit_code.
  - Read-select register sel_q, I/O read register io_q, uart_rx_ack.
  - Outputs derived from these read 0 afterwards: uart_tx_valid, io_buffer_full, cpu_din.
- Decode: is_io = (cpu_a[17:16]==2'b11).
  - RAM path is combinational: ram_a = cpu_a[16:0], ram_dout = cpu_dout.
  - ram_we = cpu_wr & ~is_io & rdy_in.
- I/O write, is_io & cpu_wr & rdy_in, by cpu_a[2:0]:
  - 0: push cpu_dout into the TX FIFO. If the FIFO is full and no pop occurs this cycle, drop the byte and set tx_overflow.
  - 4: set program_finish; exit_code <= cpu_dout.
  - other offsets: ignored.
- I/O read, is_io & ~cpu_wr & rdy_in, by cpu_a[2:0]:
  - 0: if uart_rx_valid, io_q <= uart_rx_data and uart_rx_ack=1 on the next cycle. Otherwise io_q <= 0 and no ack.
  - 4: io_q <= {6'b0, uart_rx_valid, fifo_full}.
  - other offsets: io_q <= 0.
- Read return: sel_q <= is_io each enabled cycle; cpu_din = sel_q ? io_q : ram_din.
  - Latency is exactly 1 cycle for both RAM and I/O.
  - Back-to-back reads at alternating targets must each return the correct source.
- uart_rx_ack: high exactly 1 cycle per consumed byte, never 2 consecutive cycles for a single read.
- TX FIFO:
  - Circular buffer; wr_ptr and rd_ptr are TXF_AW bits and wrap modulo TXF_DEPTH. Count is TXF_AW+1 bits.
  - uart_tx_data = mem[rd_ptr]; uart_tx_valid = (count != 0).
  - Pop when uart_tx_valid & uart_tx_ready & rdy_in.
  - Simultaneous push and pop: both happen and count is unchanged. This applies when full (push accepted, no overflow) and when empty-then-push (no pop, since valid=0 at that edge).
  - io_buffer_full = (count == TXF_DEPTH), combinational from the registered count.
- rdy_in low:
  - No pointer, flag or register updates.
  - ram_we = 0, uart_rx_ack = 0.
  - cpu_din holds its last value.
- Reset mid-operation: in-flight FIFO contents are discarded; pending acks are cancelled.

Decomposition:
- Shared package or defines: I/O base select 2'b11, offsets UART_DATA=3'd0 and STATUS_HALT=3'd4, TXF_DEPTH/TXF_AW.
- One sub-module: tx_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count and an active-low synchronous reset.
- Decode, RX handshake and read-mux stay in mem_io_bridge.

Test Plan:
- Reset, then RAM write 0x00123 with 0xA5, then read 0x00123 -> ram_we pulses once; cpu_din == 0xA5 exactly 1 cycle after the read address.
- 8 writes to 0x30000 (0x01..0x08) with uart_tx_ready=0 -> io_buffer_full=1. A 9th write (0x09) -> tx_overflow=1. Then raise ready -> uart_tx_data emits 0x01..0x08 in order, 0x09 never appears.
- FIFO full, write 0x55 while uart_tx_ready=1 -> head popped, 0x55 enqueued, count stays 8, tx_overflow stays 0. Also run 20 push/pop cycles to confirm pointer wrap.
- uart_rx_valid=1, uart_rx_data=0x3C, read 0x30000 -> cpu_din=0x3C next cycle, single-cycle uart_rx_ack. With rx_valid=0 -> cpu_din=0x00, no ack.
- Read 0x30004 with FIFO full and rx_valid=1 -> cpu_din=0x03. Write 0x2A to 0x30004 -> program_finish=1, exit_code=0x2A.
- Hold rdy_in=0 for 5 cycles during RAM writes and I/O writes -> no ram_we, no FIFO change. Assert rst_in=0 with 3 bytes queued -> uart_tx_valid=0 and all flags 0 next cycle.
